// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Holds the PC and the word-addressed instruction memory, fetches one word
// per cycle and loads the IF/ID pipeline register (FD_PC, FD_IR, FD_valid).
// A taken branch (from EX) beats a jump (from ID), which beats a load-use
// stall. Each redirect leaves a NOP bubble in IF/ID.
module if_stage #(
  parameter int          IM_DEPTH = 128,
  parameter int          IM_AW    = 7,
  parameter logic [31:0] NOP_WORD = 32'h00000020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] pc,
  output logic [31:0] FD_PC,
  output logic [31:0] FD_IR,
  output logic        FD_valid
);

  // Instruction store. Never reset; benches preload it hierarchically.
  logic [31:0] instruction [0:IM_DEPTH-1];

  // Program counter (byte address). PC[1:0] plays no part in the fetch.
  logic [31:0] PC;

  logic [IM_AW-1:0] fetch_index;
  logic             fetch_out_of_range;
  logic [31:0]      fetch_word;
  logic [31:0]      pc_plus4;
  logic [31:0]      jump_target;

  // Combinational fetch: any address beyond the store returns a bubble word
  // rather than aliasing back into the array.
  always_comb begin
    fetch_index        = PC[IM_AW+1:2];
    fetch_out_of_range = |PC[31:IM_AW+2];
    fetch_word         = fetch_out_of_range ? NOP_WORD : instruction[fetch_index];
  end

  // Sequential PC and jump target. FD_PC holds the jump's own PC+4, so its
  // top nibble selects the 256 MB region the jump lands in.
  always_comb begin
    pc_plus4    = PC + 32'd4;
    jump_target = {FD_PC[31:28], jump_index, 2'b00};
  end

  // PC and IF/ID register update with reset > branch > jump > stall > fetch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      PC       <= 32'd0;
      FD_PC    <= 32'd0;
      FD_IR    <= NOP_WORD;
      FD_valid <= 1'b0;
    end else if (branch_taken) begin
      // The branch is older than anything in ID, so it wins over jump/stall.
      PC       <= branch_target;
      FD_PC    <= 32'd0;
      FD_IR    <= NOP_WORD;
      FD_valid <= 1'b0;
    end else if (jump) begin
      // Redirect drops any stall; ID re-asserts it if the hazard persists.
      PC       <= jump_target;
      FD_PC    <= 32'd0;
      FD_IR    <= NOP_WORD;
      FD_valid <= 1'b0;
    end else if (!stall) begin
      PC       <= pc_plus4;
      FD_PC    <= pc_plus4;
      FD_IR    <= fetch_word;
      FD_valid <= 1'b1;
    end
  end

  assign pc = PC;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios from the fetch-stage
// behaviour plus a randomized run against a cycle-level behavioural model.
module tb_if_stage;

  localparam int          DEPTH = 128;
  localparam logic [31:0] NOP   = 32'h00000020;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] pc;
  logic [31:0] FD_PC;
  logic [31:0] FD_IR;
  logic        FD_valid;

  int checks   = 0;
  int failures = 0;

  // Bench copy of the instruction store and the behavioural model state.
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] m_pc;
  logic [31:0] m_fdpc;
  logic [31:0] m_ir;
  logic        m_v;

  logic [96:0] obs;
  assign obs = {pc, FD_PC, FD_IR, FD_valid};

  if_stage #(.IM_DEPTH(DEPTH), .IM_AW(7), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index),
    .pc(pc), .FD_PC(FD_PC), .FD_IR(FD_IR), .FD_valid(FD_valid)
  );

  always #5 clk = ~clk;

  // Word at byte address a: the stored word if inside the 512-byte store, else a bubble.
  function automatic logic [31:0] m_fetch(input logic [31:0] a);
    if (a < 32'(DEPTH * 4)) return mem[int'(a >> 2)];
    return NOP;
  endfunction

  task automatic write_word(input int idx, input logic [31:0] w);
    mem[idx] = w;
    dut.instruction[idx] = w;
  endtask

  // Apply one cycle of inputs, advance the model by the stage's priority rules,
  // then sample the DUT 1 time unit after the edge.
  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] bt,
                      input logic j, input logic [25:0] ji);
    rst = r; stall = s; branch_taken = b; branch_target = bt; jump = j; jump_index = ji;
    @(posedge clk);
    if (!r) begin
      m_pc = 0; m_fdpc = 0; m_ir = NOP; m_v = 1'b0;
    end else if (b) begin
      m_pc = bt; m_fdpc = 0; m_ir = NOP; m_v = 1'b0;
    end else if (j) begin
      m_pc = (m_fdpc & 32'hF000_0000) + 32'(ji) * 4;
      m_fdpc = 0; m_ir = NOP; m_v = 1'b0;
    end else if (!s) begin
      m_ir = m_fetch(m_pc);
      m_pc = m_pc + 4;
      m_fdpc = m_pc;
      m_v = 1'b1;
    end
    #1;
    $display("cycle rst=%b stall=%b br=%b bt=%h j=%b ji=%h -> pc=%h fd_pc=%h fd_ir=%h v=%b",
             r, s, b, bt, j, ji, pc, FD_PC, FD_IR, FD_valid);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
  endtask

  task automatic test_reset();
    logic [96:0] e;
    do_reset();
    step(1'b1, 1'b0, 1'b1, 32'd40, 1'b0, 26'd0);
    checks++;
    if (pc !== 32'd40) begin
      failures++; $display("FAIL reset_preload pc got=%h exp=%h", pc, 32'd40);
    end
    do_reset();
    do_reset();
    e = {32'd0, 32'd0, NOP, 1'b0};
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", obs, e);
    end
    idle();
    e = {32'd4, 32'd4, mem[0], 1'b1};
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL reset_release got=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_sequential();
    logic [96:0] e;
    do_reset();
    for (int n = 0; n < 5; n++) begin
      idle();
      e = {32'(4 * (n + 1)), 32'(4 * (n + 1)), mem[n], 1'b1};
      checks++;
      if (obs !== e) begin
        failures++; $display("FAIL sequential[%0d] got=%h exp=%h", n, obs, e);
      end
    end
  endtask

  task automatic test_stall();
    logic [96:0] e;
    do_reset();
    idle();
    idle();
    e = {32'd8, 32'd8, mem[1], 1'b1};
    for (int n = 0; n < 2; n++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
      checks++;
      if (obs !== e) begin
        failures++; $display("FAIL stall_hold[%0d] got=%h exp=%h", n, obs, e);
      end
    end
    idle();
    e = {32'd12, 32'd12, mem[2], 1'b1};
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL stall_release got=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_jump();
    logic [96:0] e;
    do_reset();
    idle();
    checks++;
    if (FD_IR !== 32'h0800000F || FD_PC !== 32'd4) begin
      failures++; $display("FAIL jump_setup fd_ir=%h fd_pc=%h exp fd_ir=0800000f fd_pc=4", FD_IR, FD_PC);
    end
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 26'd15);
    e = {32'd60, 32'd0, NOP, 1'b0};
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL jump_bubble got=%h exp=%h", obs, e);
    end
    idle();
    e = {32'd64, 32'd64, mem[15], 1'b1};
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL jump_target_fetch got=%h exp=%h", obs, e);
    end
    // Upper nibble of the target comes from FD_PC, not from the current PC.
    step(1'b1, 1'b0, 1'b1, 32'h7000_0010, 1'b0, 26'd0);
    idle();
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 26'd3);
    checks++;
    if (pc !== 32'h7000_000C) begin
      failures++; $display("FAIL jump_region pc got=%h exp=%h", pc, 32'h7000_000C);
    end
  endtask

  task automatic test_priority();
    logic [96:0] e;
    do_reset();
    idle();
    idle();
    step(1'b1, 1'b1, 1'b1, 32'd36, 1'b1, 26'd15);
    e = {32'd36, 32'd0, NOP, 1'b0};
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL branch_over_jump_stall got=%h exp=%h", obs, e);
    end
    idle();
    e = {32'd40, 32'd40, mem[9], 1'b1};
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL branch_target_fetch got=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_bounds();
    logic [96:0] e;
    // Last in-range word.
    step(1'b1, 1'b0, 1'b1, 32'd508, 1'b0, 26'd0);
    idle();
    e = {32'd512, 32'd512, mem[127], 1'b1};
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL bound_last_word got=%h exp=%h", obs, e);
    end
    idle();
    e = {32'd516, 32'd516, NOP, 1'b1};
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL bound_out_of_range got=%h exp=%h", obs, e);
    end
    // PC+4 wraps modulo 2^32; low address bits are ignored by the fetch.
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'd0);
    idle();
    e = {32'd0, 32'd0, NOP, 1'b1};
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL bound_wrap got=%h exp=%h", obs, e);
    end
    step(1'b1, 1'b0, 1'b1, 32'd23, 1'b0, 26'd0);
    idle();
    e = {32'd27, 32'd27, mem[5], 1'b1};
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL unaligned_pc got=%h exp=%h", obs, e);
    end
    // Reset during a stall.
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
    e = {32'd0, 32'd0, NOP, 1'b0};
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL reset_mid_stall got=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_random();
    logic        r, s, b, j;
    logic [31:0] bt;
    logic [25:0] ji;
    logic [31:0] w;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      r  = ($urandom_range(0, 31) != 0);
      s  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 7) == 0);
      j  = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0:       bt = 32'($urandom_range(0, DEPTH - 1)) * 4;
        1:       bt = $urandom;
        2:       bt = 32'($urandom_range(0, 520));
        default: bt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      endcase
      ji = ($urandom_range(0, 3) == 0) ? 26'($urandom) : 26'($urandom_range(0, DEPTH + 3));
      if ($urandom_range(0, 15) == 0) begin
        w = $urandom;
        write_word(int'($urandom_range(0, DEPTH - 1)), w);
      end
      step(r, s, b, bt, j, ji);
      checks++;
      if (obs !== {m_pc, m_fdpc, m_ir, m_v}) begin
        failures++;
        $display("FAIL random[%0d] got=%h exp=%h", n, obs, {m_pc, m_fdpc, m_ir, m_v});
      end
    end
  endtask

  initial begin
    logic [31:0] r32;
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    jump = 1'b0; jump_index = 26'd0;
    m_pc = 0; m_fdpc = 0; m_ir = NOP; m_v = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      r32 = $urandom;
      write_word(i, {r32[31:7], 7'(i)});
    end
    write_word(0, 32'h0800000F);

    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_priority();
    test_bounds();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
